// File: rtl/vga_pkg.sv
// Shared VGA raster constants, widths and bus payload types for the scan compositor slice.
package vga_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CH_W    = 4;
    localparam int unsigned RGB_W   = 3 * CH_W;
    localparam int unsigned ANIM_W  = 6;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [RGB_W-1:0] BG_COLOR_DEF  = 12'h04A;
    localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 12'hF0F;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb444_t;

    // Per-pixel raster flags carried through the sprite-latency delay line
    typedef struct packed {
        logic vis;
        logic hs_n;
        logic vs_n;
        logic in_area;
    } scan_flags_t;

    localparam scan_flags_t FLAGS_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, in_area: 1'b0};

endpackage

// File: rtl/vga_scan_compositor_if.sv
// Raster bus between the compositor (master) and sprite blocks / display pins (slave).
interface vga_scan_compositor_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] hCount;
    logic [CNT_W-1:0] vCount;
    logic [RGB_W-1:0] sprite_pixel;
    logic             in_sprite_area;
    logic             hSync;
    logic             vSync;
    logic [CH_W-1:0]  vgaR;
    logic [CH_W-1:0]  vgaG;
    logic [CH_W-1:0]  vgaB;
    logic             bright;
    logic             frame_tick;
    logic             slow_anim_tick;

    modport master (
        output hCount, vCount, hSync, vSync, vgaR, vgaG, vgaB, bright,
               frame_tick, slow_anim_tick,
        input  sprite_pixel, in_sprite_area
    );

    modport slave (
        input  hCount, vCount, hSync, vSync, vgaR, vgaG, vgaB, bright,
               frame_tick, slow_anim_tick,
        output sprite_pixel, in_sprite_area
    );

endinterface

// File: rtl/vga_scan_counter.sv
// Pixel-clock divider, hCount/vCount raster counters and registered frame_tick.
module vga_scan_counter
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_TOT   = H_TOTAL,
    parameter int unsigned V_TOT   = V_TOTAL
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_h_count,
    output logic [CNT_W-1:0] o_v_count,
    output logic             o_frame_pre_c,
    output logic             o_frame_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_h_count;
    logic [CNT_W-1:0] r_v_count;
    logic             r_frame_tick;
    logic             w_pix_en;
    logic             w_h_last;
    logic             w_v_last;
    logic             w_frame_pre;

    assign w_pix_en = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_h_last = (r_h_count == CNT_W'(H_TOT - 1));
    assign w_v_last = (r_v_count == CNT_W'(V_TOT - 1));
    // One clk ahead of the last pixel's pix_en, so frame_tick can be registered yet coincide with it
    assign w_frame_pre = (r_div == DIV_W'(CLK_DIV - 2)) && w_h_last && w_v_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div        <= '0;
            r_h_count    <= '0;
            r_v_count    <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_pre;
            r_div        <= w_pix_en ? '0 : r_div + DIV_W'(1);
            if (w_pix_en) begin
                if (w_h_last) begin
                    r_h_count <= '0;
                    r_v_count <= w_v_last ? '0 : r_v_count + CNT_W'(1);
                end else begin
                    r_h_count <= r_h_count + CNT_W'(1);
                end
            end
        end
    end

    assign o_h_count     = r_h_count;
    assign o_v_count     = r_v_count;
    assign o_frame_pre_c = w_frame_pre;
    assign o_frame_tick  = r_frame_tick;

endmodule

// File: rtl/vga_scan_compositor.sv
// VGA raster compositor: counts, latency-aligned sync/visible decode, colour mux and animation tick.
// Optional colour-key transparency is enabled by defining SPRITE_TRANSPARENCY_EN.
module vga_scan_compositor
    import vga_pkg::*;
#(
    parameter int unsigned        CLK_DIV    = 4,
    parameter int unsigned        H_VIS      = vga_pkg::H_VIS,
    parameter int unsigned        H_FP       = vga_pkg::H_FP,
    parameter int unsigned        H_SYNC     = vga_pkg::H_SYNC,
    parameter int unsigned        H_BP       = vga_pkg::H_BP,
    parameter int unsigned        V_VIS      = vga_pkg::V_VIS,
    parameter int unsigned        V_FP       = vga_pkg::V_FP,
    parameter int unsigned        V_SYNC     = vga_pkg::V_SYNC,
    parameter int unsigned        V_BP       = vga_pkg::V_BP,
    parameter int unsigned        SPRITE_LAT = 1,
    parameter int unsigned        ANIM_DIV   = 6,
    parameter logic [RGB_W-1:0]   BG_COLOR   = BG_COLOR_DEF
`ifdef SPRITE_TRANSPARENCY_EN
    ,
    parameter logic [RGB_W-1:0]   KEY_COLOR  = KEY_COLOR_DEF
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_scan_compositor_if.master bus
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0]  w_h_count;
    logic [CNT_W-1:0]  w_v_count;
    logic              w_frame_pre;
    logic              w_frame_tick;
    scan_flags_t       w_raw;
    scan_flags_t       w_dly;
    rgb444_t           w_rgb;
    scan_flags_t       r_pipe [SPRITE_LAT];
    rgb444_t           r_rgb;
    logic              r_hs_n;
    logic              r_vs_n;
    logic              r_bright;
    logic              r_slow_tick;
    logic [ANIM_W-1:0] r_anim;

    vga_scan_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOT   (H_TOT),
        .V_TOT   (V_TOT)
    ) u_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .o_h_count     (w_h_count),
        .o_v_count     (w_v_count),
        .o_frame_pre_c (w_frame_pre),
        .o_frame_tick  (w_frame_tick)
    );

    // Raw decode straight from the current counts
    always_comb begin
        w_raw         = FLAGS_IDLE;
        w_raw.vis     = (w_h_count < CNT_W'(H_VIS)) && (w_v_count < CNT_W'(V_VIS));
        w_raw.hs_n    = !((w_h_count >= CNT_W'(H_VIS + H_FP)) &&
                          (w_h_count <  CNT_W'(H_VIS + H_FP + H_SYNC)));
        w_raw.vs_n    = !((w_v_count >= CNT_W'(V_VIS + V_FP)) &&
                          (w_v_count <  CNT_W'(V_VIS + V_FP + V_SYNC)));
        w_raw.in_area = bus.in_sprite_area;
    end

    // Delay the flags so they meet sprite_pixel from the same pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SPRITE_LAT); i++) begin
                r_pipe[i] <= FLAGS_IDLE;
            end
        end else begin
            r_pipe[0] <= w_raw;
            for (int i = 1; i < int'(SPRITE_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_dly = r_pipe[SPRITE_LAT-1];

    always_comb begin
        w_rgb = '0;
        if (w_dly.vis) begin
            if (w_dly.in_area) begin
                w_rgb = rgb444_t'(bus.sprite_pixel);
`ifdef SPRITE_TRANSPARENCY_EN
                if (bus.sprite_pixel == KEY_COLOR) begin
                    w_rgb = rgb444_t'(BG_COLOR);
                end
`endif
            end else begin
                w_rgb = rgb444_t'(BG_COLOR);
            end
        end
    end

    // Output register; slow tick is pre-decoded so it lands with frame_tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb       <= '0;
            r_hs_n      <= 1'b1;
            r_vs_n      <= 1'b1;
            r_bright    <= 1'b0;
            r_slow_tick <= 1'b0;
            r_anim      <= '0;
        end else begin
            r_rgb       <= w_rgb;
            r_hs_n      <= w_dly.hs_n;
            r_vs_n      <= w_dly.vs_n;
            r_bright    <= w_dly.vis;
            r_slow_tick <= w_frame_pre && (r_anim == ANIM_W'(ANIM_DIV - 1));
            if (w_frame_tick) begin
                r_anim <= (r_anim == ANIM_W'(ANIM_DIV - 1)) ? '0 : r_anim + ANIM_W'(1);
            end
        end
    end

    assign bus.hCount         = w_h_count;
    assign bus.vCount         = w_v_count;
    assign bus.hSync          = r_hs_n;
    assign bus.vSync          = r_vs_n;
    assign bus.vgaR           = r_rgb.r;
    assign bus.vgaG           = r_rgb.g;
    assign bus.vgaB           = r_rgb.b;
    assign bus.bright         = r_bright;
    assign bus.frame_tick     = w_frame_tick;
    assign bus.slow_anim_tick = r_slow_tick;

endmodule
